serial_add_block: RTL and testbench
===================================

SERIAL_ADD_BLOCK -- requirements
Module: serial_add_block

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4: bits per lane per digit.
REQ-002 SHALL have parameter LANES, default 2: independent adder lanes; lane k occupies bits [k*DIGIT_W +: DIGIT_W] of every bus.
REQ-003 SHALL have parameter NUM_DIGITS, default 4: digits per word; word width = DIGIT_W*NUM_DIGITS.
REQ-004 SHALL have parameter NEG_MASK, default 0, LANES bits: bit k set means lane k computes a-b; clear means a+b.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port io_start, input, 1: the current io_valid digit is digit 0 of a new word.
REQ-008 SHALL have port io_valid, input, 1: io_a and io_b hold a digit this cycle.
REQ-009 SHALL have ports io_a and io_b, input, LANES*DIGIT_W: operand digits, least-significant digit first.
REQ-010 SHALL have port io_out, output, LANES*DIGIT_W: registered sum digits.
REQ-011 SHALL have port io_out_valid, output, 1: io_out holds a result digit.
REQ-012 SHALL have port io_out_last, output, 1: io_out holds digit NUM_DIGITS-1.
REQ-013 SHALL have port io_overflow, output, LANES: per-lane two's-complement overflow; non-zero only while io_out_last=1.

Function
REQ-014 SHALL use states IDLE and RUN, with a digit counter of ceil(log2(NUM_DIGITS)) bits and one carry register per lane.
REQ-015 SHALL treat io_start as meaningful only when io_valid=1; io_start with io_valid=0 SHALL have no effect.
REQ-016 SHALL, on an io_valid=1 and io_start=1 digit in any state, use carry-in NEG_MASK[k] per lane, set counter=1 and go to RUN (restart; any partial word is abandoned without a last flag).
REQ-017 SHALL, in RUN on an io_valid=1 and io_start=0 digit, use the stored carry per lane and increment the counter.
REQ-018 SHALL, per lane, compute a + (NEG_MASK[k] ? ~b : b) + carry-in over DIGIT_W bits; the carry-out is stored as the next carry.
REQ-019 SHALL register the sum digit, valid and last flags, giving a latency of exactly 1 cycle from the input digit to io_out and io_out_valid.
REQ-020 SHALL flag the digit with counter index NUM_DIGITS-1 as last, return to IDLE after it, and clear the counter.
REQ-021 SHALL flag the start digit as last when NUM_DIGITS=1, and stay in IDLE after it.
REQ-022 SHALL, when io_valid=0 (stall), hold carry, counter and state, and drive io_out_valid=0 on the next cycle.
REQ-023 SHALL drop io_valid=1 and io_start=0 digits in IDLE, with no output and no state change.
REQ-024 SHALL set io_overflow[k] on the last digit to (carry into lane MSB) XOR (carry out of lane MSB).
REQ-025 SHALL accept a start digit in the cycle immediately after a last digit; back-to-back words need no bubble.
REQ-026 SHALL hold io_out at its previous value when io_out_valid=0; only the flags are cleared.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force state=IDLE, counter=0, carries=0, io_out=0, io_out_valid=0, io_out_last=0 and io_overflow=0.
REQ-028 SHALL, after reset deasserts, require an io_start digit before producing any output; a word in progress at reset is lost.

Verification (DIGIT_W=4, LANES=2, NUM_DIGITS=4, NEG_MASK=2'b01)
REQ-029 SHALL cover basic operation: lane1 0x1234+0x0FFF and lane0 0x0005-0x0007, fed over 4 consecutive digits -> io_out digits lane1 3,3,2,2 and lane0 E,F,F,F; last flag on the 4th output; io_overflow=0.
REQ-030 SHALL cover overflow: lane1 0x7FFF+0x0001 and lane0 0x8000-0x0001 -> lane1 0x8000 and lane0 0x7FFF; io_overflow=2'b11 only on the last output.
REQ-031 SHALL cover stalls: REQ-029 stimulus with io_valid=0 for 3 cycles between digits 1 and 2 -> identical digits, io_out_valid=0 during the gaps, last flag on the 4th valid output.
REQ-032 SHALL cover restart: io_start reasserted at digit 2, then a full new word -> the first two outputs are not flagged last, and the new word's result is correct.
REQ-033 SHALL cover reset mid-word: reset_n pulsed low after digit 1 -> all outputs 0 immediately; following non-start digits dropped; next start word correct.
REQ-034 SHALL cover back-to-back words: two words with no gap -> 8 consecutive valid outputs with last flags on outputs 4 and 8, and carry reinitialised at word 2.

Source files
------------

// File: rtl/serial_add_block.sv
// Digit-serial multi-lane adder/subtractor: one digit per lane per cycle, LSD first,
// with per-lane carry chaining across digits and two's-complement overflow on the last digit.
module serial_add_block #(
  parameter int unsigned     DIGIT_W    = 4,
  parameter int unsigned     LANES      = 2,
  parameter int unsigned     NUM_DIGITS = 4,
  parameter logic [LANES-1:0] NEG_MASK  = '0
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       io_start,
  input  logic                       io_valid,
  input  logic [LANES*DIGIT_W-1:0]   io_a,
  input  logic [LANES*DIGIT_W-1:0]   io_b,
  output logic [LANES*DIGIT_W-1:0]   io_out,
  output logic                       io_out_valid,
  output logic                       io_out_last,
  output logic [LANES-1:0]           io_overflow
);

  localparam int unsigned BUS_W = LANES * DIGIT_W;
  localparam int unsigned SUM_W = DIGIT_W + 1;
  localparam int unsigned CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LANES-1:0]   carry_q;
  logic [BUS_W-1:0]   out_q;
  logic               valid_q;
  logic               last_q;
  logic [LANES-1:0]   ovf_q;

  logic               take_start;
  logic               take;
  logic [CNT_W-1:0]   idx;
  logic               is_last;
  logic [BUS_W-1:0]   sum_d;
  logic [LANES-1:0]   carry_d;
  logic [LANES-1:0]   ovf_d;

  // Digit acceptance and per-lane digit add; a start digit reloads the carry from NEG_MASK.
  always_comb begin
    take_start = io_valid & io_start;
    take       = take_start | (io_valid & ~io_start & (state_q == RUN));
    idx        = take_start ? '0 : cnt_q;
    is_last    = (idx == LAST_IDX);
    sum_d      = '0;
    carry_d    = carry_q;
    ovf_d      = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      logic [DIGIT_W-1:0] a_l;
      logic [DIGIT_W-1:0] b_l;
      logic               cin;
      logic [SUM_W-1:0]   full;
      logic               c_msb_in;
      a_l  = io_a[k*DIGIT_W +: DIGIT_W];
      b_l  = NEG_MASK[k] ? ~io_b[k*DIGIT_W +: DIGIT_W] : io_b[k*DIGIT_W +: DIGIT_W];
      cin  = take_start ? NEG_MASK[k] : carry_q[k];
      full = SUM_W'(a_l) + SUM_W'(b_l) + SUM_W'(cin);
      // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
      c_msb_in = a_l[DIGIT_W-1] ^ b_l[DIGIT_W-1] ^ full[DIGIT_W-1];
      sum_d[k*DIGIT_W +: DIGIT_W] = full[DIGIT_W-1:0];
      carry_d[k] = full[DIGIT_W];
      ovf_d[k]   = c_msb_in ^ full[DIGIT_W];
    end
  end

  // State, counter, carries and registered outputs; io_out holds when no digit is taken.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= '0;
    end else if (take) begin
      out_q   <= sum_d;
      valid_q <= 1'b1;
      last_q  <= is_last;
      ovf_q   <= is_last ? ovf_d : '0;
      carry_q <= carry_d;
      if (is_last) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= RUN;
        cnt_q   <= idx + CNT_W'(1);
      end
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= '0;
    end
  end

  assign io_out       = out_q;
  assign io_out_valid = valid_q;
  assign io_out_last  = last_q;
  assign io_overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_block.sv
// Scoreboard bench for serial_add_block: lane1 adds, lane0 subtracts, 4 hex digits per word.
module tb_serial_add_block;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       io_start = 1'b0;
  logic       io_valid = 1'b0;
  logic [7:0] io_a = '0;
  logic [7:0] io_b = '0;
  logic [7:0] io_out;
  logic       io_out_valid;
  logic       io_out_last;
  logic [1:0] io_overflow;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic [1:0] ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  serial_add_block #(
    .DIGIT_W(4), .LANES(2), .NUM_DIGITS(4), .NEG_MASK(2'b01)
  ) dut (
    .clock(clock), .reset_n(reset_n), .io_start(io_start), .io_valid(io_valid),
    .io_a(io_a), .io_b(io_b), .io_out(io_out), .io_out_valid(io_out_valid),
    .io_out_last(io_out_last), .io_overflow(io_overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] dig(input logic [15:0] x1, input logic [15:0] x0, input int i);
    return {x1[4*i +: 4], x0[4*i +: 4]};
  endfunction

  // Reference: whole-word arithmetic, split into the first n expected output digits.
  task automatic push_word(input logic [15:0] a1, input logic [15:0] b1,
                           input logic [15:0] a0, input logic [15:0] b0, input int n);
    logic [15:0] r1, r0;
    logic        o1, o0;
    exp_t        e;
    r1 = a1 + b1;
    r0 = a0 - b0;
    o1 = (a1[15] == b1[15]) && (r1[15] != a1[15]);
    o0 = (a0[15] != b0[15]) && (r0[15] != a0[15]);
    for (int i = 0; i < n; i++) begin
      e.d    = dig(r1, r0, i);
      e.last = (i == 3);
      e.ovf  = (i == 3) ? {o1, o0} : 2'b00;
      q.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clock);
    io_valid = v;
    io_start = s;
    io_a     = a;
    io_b     = b;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({io_out, io_out_valid, io_out_last, io_overflow} !== 12'h0) begin
      bad++;
      $display("FAIL reset_async: got %h want 000", {io_out, io_out_valid, io_out_last, io_overflow});
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h11, 8'h22);
      total++;
      if (io_out_valid !== 1'b0 || io_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_nostart step%0d: got v=%b out=%h want v=0 out=00", i, io_out_valid, io_out);
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    push_word(16'h1234, 16'h0FFF, 16'h0005, 16'h0007, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i == 0), dig(16'h1234, 16'h0005, i), dig(16'h0FFF, 16'h0007, i));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL basic_valid d%0d: got v=%b want v=1", i, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL basic d%0d: got %h/%b/%b want %h/%b/%b", i, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    total++;
    if (io_out !== 8'h2F) begin
      bad++;
      $display("FAIL basic_msd: got %h want 2f", io_out);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_overflow();
    exp_t e;
    push_word(16'h7FFF, 16'h0001, 16'h8000, 16'h0001, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i == 0), dig(16'h7FFF, 16'h8000, i), dig(16'h0001, 16'h0001, i));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL ovf_valid d%0d: got v=%b want v=1", i, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL ovf d%0d: got %h/%b/%b want %h/%b/%b", i, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    total++;
    if (io_overflow !== 2'b11 || io_out !== 8'h87) begin
      bad++;
      $display("FAIL ovf_last: got ovf=%b out=%h want ovf=11 out=87", io_overflow, io_out);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    total++;
    if (io_overflow !== 2'b00) begin
      bad++;
      $display("FAIL ovf_clear: got %b want 00", io_overflow);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   di;
    logic [7:0] held;
    logic v;
    di = 0;
    push_word(16'h1234, 16'h0FFF, 16'h0005, 16'h0007, 4);
    for (int step = 0; step < 7; step++) begin
      v = !(step >= 2 && step <= 4);
      held = io_out;
      if (v) drive(1'b1, 1'(di == 0), dig(16'h1234, 16'h0005, di), dig(16'h0FFF, 16'h0007, di));
      else   drive(1'b0, 1'b1, 8'hAA, 8'h55);
      total++;
      if (!v) begin
        if (io_out_valid !== 1'b0 || io_out_last !== 1'b0 || io_out !== held) begin
          bad++;
          $display("FAIL stall_gap step%0d: got v=%b l=%b out=%h want v=0 l=0 out=%h", step, io_out_valid, io_out_last, io_out, held);
        end
      end else if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL stall_valid d%0d: got v=%b want v=1", di, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL stall d%0d: got %h/%b/%b want %h/%b/%b", di, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
      if (v) di++;
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_restart();
    exp_t e;
    logic [15:0] a1, b1, a0, b0;
    push_word(16'h1234, 16'h0FFF, 16'h0005, 16'h0007, 2);
    push_word(16'h0F0F, 16'h00F1, 16'h0100, 16'h0001, 4);
    for (int s = 0; s < 6; s++) begin
      if (s < 2) begin a1 = 16'h1234; b1 = 16'h0FFF; a0 = 16'h0005; b0 = 16'h0007; end
      else       begin a1 = 16'h0F0F; b1 = 16'h00F1; a0 = 16'h0100; b0 = 16'h0001; end
      drive(1'b1, 1'(s == 0 || s == 2), dig(a1, a0, (s < 2) ? s : s - 2), dig(b1, b0, (s < 2) ? s : s - 2));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL restart_valid s%0d: got v=%b want v=1", s, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL restart s%0d: got %h/%b/%b want %h/%b/%b", s, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    push_word(16'h1234, 16'h0FFF, 16'h0005, 16'h0007, 2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'(i == 0), dig(16'h1234, 16'h0005, i), dig(16'h0FFF, 16'h0007, i));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL rmid_valid d%0d: got v=%b want v=1", i, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL rmid d%0d: got %h/%b/%b want %h/%b/%b", i, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    @(negedge clock);
    io_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    total++;
    if ({io_out, io_out_valid, io_out_last, io_overflow} !== 12'h0) begin
      bad++;
      $display("FAIL rmid_async: got %h want 000", {io_out, io_out_valid, io_out_last, io_overflow});
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 2; i < 4; i++) begin
      drive(1'b1, 1'b0, dig(16'h1234, 16'h0005, i), dig(16'h0FFF, 16'h0007, i));
      total++;
      if (io_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rmid_drop d%0d: got v=%b want v=0", i, io_out_valid);
      end
    end
    push_word(16'h4321, 16'h1111, 16'h0010, 16'h0020, 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i == 0), dig(16'h4321, 16'h0010, i), dig(16'h1111, 16'h0020, i));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL rmid_new_valid d%0d: got v=%b want v=1", i, io_out_valid);
      end else begin
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL rmid_new d%0d: got %h/%b/%b want %h/%b/%b", i, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] w [2][4];
    int   nvalid;
    nvalid = 0;
    // Word 1 leaves lane1 carry=1 and lane0 carry=0: a stale carry corrupts word 2.
    w[0] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0001};
    w[1] = '{16'h0001, 16'h0001, 16'h0003, 16'h0001};
    for (int j = 0; j < 2; j++) push_word(w[j][0], w[j][1], w[j][2], w[j][3], 4);
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 1'(s % 4 == 0), dig(w[s/4][0], w[s/4][2], s % 4), dig(w[s/4][1], w[s/4][3], s % 4));
      total++;
      if (io_out_valid !== 1'b1 || q.size() == 0) begin
        bad++;
        $display("FAIL b2b_valid s%0d: got v=%b want v=1", s, io_out_valid);
      end else begin
        nvalid++;
        e = q.pop_front();
        if ({io_out, io_out_last, io_overflow} !== e) begin
          bad++;
          $display("FAIL b2b s%0d: got %h/%b/%b want %h/%b/%b", s, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
        end
      end
    end
    total++;
    if (nvalid != 8) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 8", nvalid);
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    exp_t e;
    logic [15:0] a1, b1, a0, b0;
    for (int n = 0; n < 6; n++) begin
      a1 = 16'($urandom); b1 = 16'($urandom);
      a0 = 16'($urandom); b0 = 16'($urandom);
      push_word(a1, b1, a0, b0, 4);
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'(i == 0), dig(a1, a0, i), dig(b1, b0, i));
        total++;
        if (io_out_valid !== 1'b1 || q.size() == 0) begin
          bad++;
          $display("FAIL rand_valid w%0d d%0d: got v=%b want v=1", n, i, io_out_valid);
        end else begin
          e = q.pop_front();
          if ({io_out, io_out_last, io_overflow} !== e) begin
            bad++;
            $display("FAIL rand w%0d d%0d: got %h/%b/%b want %h/%b/%b", n, i, io_out, io_out_last, io_overflow, e.d, e.last, e.ovf);
          end
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
